// File: rtl/imem_fetch_resp_pkg.sv
// imem_pkg: shared types and constants for the instruction fetch block.
//   resp_t       : response record carried through the response FIFO
//   NOP          : instruction word returned for a faulting fetch
//   FIFO_DEPTH   : number of buffered response entries
//   fifo_state_e : occupancy states of the 2-entry response FIFO
package imem_pkg;

  localparam logic [31:0] NOP        = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } resp_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_e;

  // Occupancy count is the state encoding itself.
  function automatic logic [1:0] state_count(input fifo_state_e s);
    return logic'(s == FULL) ? 2'd2 : ((s == ONE) ? 2'd1 : 2'd0);
  endfunction

endpackage

// File: rtl/imem_fetch_resp_if.sv
// imem_fetch_resp_if: fetch request / response handshake bundle.
//   req_valid, req_addr   : PC side presents a byte fetch address
//   req_ready             : fetch block accepts the request this cycle
//   resp_valid, resp_*    : fetched instruction at the response head
//   resp_ready            : decode side consumes the response
// Modports: slave = fetch block, master = PC/decode side.
interface imem_fetch_resp_if;

  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_err;

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_addr, resp_err
  );

endinterface

// File: rtl/imem_fetch_resp_fifo2.sv
// resp_fifo2: 2-entry response FIFO with an occupancy FSM.
//   clk, reset : clock, synchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry (ignored when empty)
//   count      : number of valid entries (0..2)
//   head       : oldest entry; only meaningful when count != 0
//
// state | meaning
// EMPTY | no entries buffered
// ONE   | entry0 holds the head
// FULL  | entry0 is the head, entry1 the next response
module resp_fifo2
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  resp_t      push_data,
  input  logic       pop,
  output logic [1:0] count,
  output resp_t      head
);

  fifo_state_e state, state_nxt;
  resp_t       entry0, entry1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop && !push) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Shift-register storage: entry0 is always the head, so the output needs no mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) entry0 <= push_data;
        ONE: begin
          if (push) begin
            if (pop) entry0 <= push_data;
            else     entry1 <= push_data;
          end
        end
        FULL: begin
          if (pop) begin
            entry0 <= entry1;
            if (push) entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = state_count(state);
  assign head  = entry0;

endmodule

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp: instruction memory with a one-cycle synchronous read stage
// feeding a 2-entry response FIFO.
//   clk, reset           : clock, synchronous active-high reset
//   bus (slave)          : fetch request / response handshake
//   prog_we/addr/data    : word-indexed memory write port
// Parameters: DEPTH (words, power of two), AW (word-index width).
// Build option: IMEM_ALIGN_CHECK_EN flags fetches with req_addr[1:0] != 0.
module imem_fetch_resp
  import imem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_fetch_resp_if.slave     bus,
  input  logic                 prog_we,
  input  logic [AW-1:0]        prog_addr,
  input  logic [31:0]          prog_data
);

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          pop;
  logic          pop_fifo;
  logic          push_fifo;
  logic          range_err;
  logic          fetch_err;
  logic          req_ready_int;
  logic          resp_valid_int;
  logic [AW-1:0] req_idx;
  logic [2:0]    occupancy;

  logic          inflight;
  logic [31:0]   rd_data;
  logic [31:0]   inflight_addr;
  logic          inflight_err;

  logic [1:0]    count;
  resp_t         fifo_head;
  resp_t         inflight_resp;
  resp_t         head;

  assign req_idx   = bus.req_addr[AW+1:2];
  assign range_err = |(bus.req_addr >> (AW + 2));

`ifdef IMEM_ALIGN_CHECK_EN
  assign fetch_err = range_err | (|bus.req_addr[1:0]);
`else
  logic unused_byte_offset;
  assign unused_byte_offset = ^bus.req_addr[1:0];
  assign fetch_err          = range_err;
`endif

  // The in-flight read result is visible at the head when the FIFO is empty,
  // giving one-cycle latency and full throughput without a third entry.
  assign resp_valid_int = !reset && ((count != 2'd0) || inflight);
  assign pop            = resp_valid_int && bus.resp_ready;
  assign occupancy      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign req_ready_int  = !reset && (occupancy < 3'd2);
  assign accept         = bus.req_valid && req_ready_int;

  assign pop_fifo  = pop && (count != 2'd0);
  assign push_fifo = inflight && !(pop && (count == 2'd0));

  always_comb begin
    inflight_resp       = '0;
    inflight_resp.instr = inflight_err ? NOP : rd_data;
    inflight_resp.addr  = inflight_addr;
    inflight_resp.err   = inflight_err;
  end

  assign head = (count != 2'd0) ? fifo_head : inflight_resp;

  // Memory contents survive reset; nonblocking update returns old data on a
  // same-cycle write and read of one word.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (accept)  rd_data <= mem[req_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
      inflight_err  <= 1'b0;
    end else begin
      inflight <= accept;
      if (accept) begin
        inflight_addr <= bus.req_addr;
        inflight_err  <= fetch_err;
      end
    end
  end

  resp_fifo2 u_resp_fifo2 (
    .clk       (clk),
    .reset     (reset),
    .push      (push_fifo),
    .push_data (inflight_resp),
    .pop       (pop_fifo),
    .count     (count),
    .head      (fifo_head)
  );

  assign bus.req_ready  = req_ready_int;
  assign bus.resp_valid = resp_valid_int;
  assign bus.resp_instr = resp_valid_int ? head.instr : 32'h0;
  assign bus.resp_addr  = resp_valid_int ? head.addr  : 32'h0;
  assign bus.resp_err   = resp_valid_int ? head.err   : 1'b0;

endmodule

// File: tb/tb_imem_fetch_resp.sv
// Scoreboard bench for imem_fetch_resp: the driver pushes hand-computed
// expectations on each accepted request; the monitor pops and compares on
// every response handshake.
module tb_imem_fetch_resp;
  import imem_pkg::*;

`ifdef IMEM_ALIGN_CHECK_EN
  localparam logic [31:0] EXP6_INSTR = 32'h0000_0000;
  localparam logic        EXP6_ERR   = 1'b1;
`else
  localparam logic [31:0] EXP6_INSTR = 32'h2009_0003;
  localparam logic        EXP6_ERR   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;

  int    tests = 0;
  int    fails = 0;
  int    pops  = 0;
  resp_t sb[$];

  imem_fetch_resp_if bus ();

  imem_fetch_resp #(.DEPTH(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic prog(input logic [7:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(posedge clk); #1;
    prog_we   = 1'b0;
  endtask

  // Presents one request until accepted (bounded) and records its expectation.
  task automatic fetch(input logic [31:0] a, input logic [31:0] instr,
                       input logic err, output int waited);
    bit done = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    waited = 0;
    while (!done && waited <= 20) begin
      @(negedge clk);
      if (bus.req_ready) begin
        sb.push_back('{instr: instr, addr: a, err: err});
        done = 1'b1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout addr %h: no req_ready within 20 cycles", a);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Monitor: compares each popped response, checks hold stability and idle zeros.
  initial begin
    bit    hold_v;
    resp_t held;
    resp_t exp;
    hold_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v) begin
          check("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
          check("hold_instr", bus.resp_instr, held.instr);
          check("hold_addr",  bus.resp_addr,  held.addr);
          check("hold_err",   {31'b0, bus.resp_err}, {31'b0, held.err});
        end
        if (bus.resp_valid && bus.resp_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_resp: got addr %h instr %h, required no response",
                     bus.resp_addr, bus.resp_instr);
          end else begin
            exp = sb.pop_front();
            check("resp_instr", bus.resp_instr, exp.instr);
            check("resp_addr",  bus.resp_addr,  exp.addr);
            check("resp_err",   {31'b0, bus.resp_err}, {31'b0, exp.err});
            pops++;
          end
        end else if (!bus.resp_valid) begin
          check("idle_fields", {bus.resp_instr ^ bus.resp_addr, 31'b0} | {31'b0, bus.resp_err}
                               | (bus.resp_instr | bus.resp_addr), 32'h0);
        end
        hold_v = bus.resp_valid && !bus.resp_ready;
        held   = '{instr: bus.resp_instr, addr: bus.resp_addr, err: bus.resp_err};
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int w3;
    int p0;
    reset          = 1'b1;
    prog_we        = 1'b0;
    prog_addr      = '0;
    prog_data      = '0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.resp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready",  {31'b0, bus.req_ready},  32'd0);
    check("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("post_rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;

    prog(8'd0, 32'h2008_0005);
    prog(8'd1, 32'h2009_0003);
    prog(8'd5, 32'h1111_5555);

    // Basic fetch and one-cycle latency
    bus.resp_ready = 1'b1;
    fetch(32'h0, 32'h2008_0005, 1'b0, w);
    check("basic_wait0", w, 0);
    @(negedge clk);
    check("lat1_valid", {31'b0, bus.resp_valid}, 32'd1);
    check("lat1_addr",  bus.resp_addr, 32'h0);
    @(posedge clk); #1;
    fetch(32'h4, 32'h2009_0003, 1'b0, w);
    check("basic_wait1", w, 0);
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back throughput
    p0 = pops;
    fetch(32'h0, 32'h2008_0005, 1'b0, w); check("tput_wait0", w, 0);
    fetch(32'h4, 32'h2009_0003, 1'b0, w); check("tput_wait1", w, 0);
    fetch(32'h0, 32'h2008_0005, 1'b0, w); check("tput_wait2", w, 0);
    fetch(32'h4, 32'h2009_0003, 1'b0, w); check("tput_wait3", w, 0);
    @(posedge clk); #1;
    check("tput_pops", pops - p0, 4);

    // Backpressure: two accepted, third waits until the first pop
    bus.resp_ready = 1'b0;
    fetch(32'h0, 32'h2008_0005, 1'b0, w); check("bp_wait0", w, 0);
    fetch(32'h4, 32'h2009_0003, 1'b0, w); check("bp_wait1", w, 0);
    fork
      fetch(32'h14, 32'h1111_5555, 1'b0, w3);
      begin
        @(negedge clk);
        check("full_req_ready_a", {31'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        check("full_req_ready_b", {31'b0, bus.req_ready}, 32'd0);
        check("full_head_addr", bus.resp_addr, 32'h0);
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("pop_accept_ready", {31'b0, bus.req_ready}, 32'd1);
        check("pop_accept_head",  bus.resp_addr, 32'h0);
      end
    join
    check("bp_wait2", w3, 2);
    repeat (5) @(posedge clk);
    #1;

    // Out of range and unaligned fetches
    fetch(32'h0000_0400, 32'h0, 1'b1, w);
    check("oor_wait", w, 0);
    fetch(32'h0000_0006, EXP6_INSTR, EXP6_ERR, w);
    check("unaligned_wait", w, 0);
    repeat (3) @(posedge clk);
    #1;

    // Write and fetch the same word in one cycle, then refetch
    prog_we   = 1'b1;
    prog_addr = 8'd5;
    prog_data = 32'hDEAD_BEEF;
    fetch(32'h14, 32'h1111_5555, 1'b0, w);
    prog_we = 1'b0;
    check("wr_rd_wait", w, 0);
    fetch(32'h14, 32'hDEAD_BEEF, 1'b0, w);
    repeat (3) @(posedge clk);
    #1;

    // Reset with one buffered and one in-flight response
    bus.resp_ready = 1'b0;
    fetch(32'h0, 32'h2008_0005, 1'b0, w);
    fetch(32'h4, 32'h2009_0003, 1'b0, w);
    reset         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    @(negedge clk);
    check("inrst_req_ready",  {31'b0, bus.req_ready},  32'd0);
    check("inrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst2_req_ready",  {31'b0, bus.req_ready},  32'd1);
    check("rst2_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst2_instr", bus.resp_instr, 32'h0);
    check("rst2_addr",  bus.resp_addr,  32'h0);
    check("rst2_err",   {31'b0, bus.resp_err}, 32'd0);
    bus.resp_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_valid", {31'b0, bus.resp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    fetch(32'h4, 32'h2009_0003, 1'b0, w);
    check("post_rst2_wait", w, 0);
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
